// File: rtl/decode_stage_if.sv
// ID-stage bus: IF-side fetch handshake, register file read/writeback and ID/EX outputs.
// master = surrounding pipeline, slave = decode_stage.
interface decode_stage_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
);
   logic                  if_valid;
   logic [31:0]           if_instr;
   logic [XLEN-1:0]       if_pc;
   logic                  id_ready;
   logic [REG_ADDR_W-1:0] read1;
   logic [REG_ADDR_W-1:0] read2;
   logic [XLEN-1:0]       data1;
   logic [XLEN-1:0]       data2;
   logic                  wb_regWrite;
   logic [REG_ADDR_W-1:0] wb_writeReg;
   logic [XLEN-1:0]       wb_writeData;
   logic                  flush;
   logic                  ex_ready;
   logic                  ex_valid;
   logic [XLEN-1:0]       ex_pc;
   logic [XLEN-1:0]       ex_rs1_val;
   logic [XLEN-1:0]       ex_rs2_val;
   logic [XLEN-1:0]       ex_imm;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic [3:0]            ex_funct;
   logic [3:0]            ex_op;
   logic                  ex_regWrite;
   logic                  ex_memRead;
   logic                  ex_memWrite;

   modport master (
      output if_valid, if_instr, if_pc, data1, data2,
             wb_regWrite, wb_writeReg, wb_writeData, flush, ex_ready,
      input  id_ready, read1, read2, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val,
             ex_imm, ex_rd, ex_funct, ex_op, ex_regWrite, ex_memRead, ex_memWrite
   );

   modport slave (
      input  if_valid, if_instr, if_pc, data1, data2,
             wb_regWrite, wb_writeReg, wb_writeData, flush, ex_ready,
      output id_ready, read1, read2, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val,
             ex_imm, ex_rd, ex_funct, ex_op, ex_regWrite, ex_memRead, ex_memWrite
   );
endinterface

// File: rtl/decode_stage.sv
// RV32I ID stage: decode, immediate generation, load-use stall and ID/EX register.
// Optional WB_BYPASS_EN forwards the same-cycle writeback value into the latched operands.
module decode_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input logic           clk,
   input logic           rst,
   decode_stage_if.slave bus
);

   typedef enum logic [6:0] {
      OPC_OP     = 7'b0110011,
      OPC_OPIMM  = 7'b0010011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_BRANCH = 7'b1100011,
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111
   } opcode_e;

   typedef enum logic [3:0] {
      EXOP_ALU_R   = 4'd0,
      EXOP_ALU_I   = 4'd1,
      EXOP_LOAD    = 4'd2,
      EXOP_STORE   = 4'd3,
      EXOP_BRANCH  = 4'd4,
      EXOP_LUI     = 4'd5,
      EXOP_AUIPC   = 4'd6,
      EXOP_JAL     = 4'd7,
      EXOP_JALR    = 4'd8,
      EXOP_ILLEGAL = 4'd15
   } exop_e;

   logic [31:0]           w_instr;
   logic [6:0]            w_opcode;
   logic [REG_ADDR_W-1:0] w_rs1;
   logic [REG_ADDR_W-1:0] w_rs2;
   logic [REG_ADDR_W-1:0] w_rd_field;
   logic [REG_ADDR_W-1:0] w_rd;
   exop_e                 w_op;
   logic [31:0]           w_imm;
   logic                  w_has_rd;
   logic                  w_use1;
   logic                  w_use2;
   logic                  w_memRead;
   logic                  w_memWrite;
   logic                  w_regWrite;
   logic                  w_hazard;
   logic                  w_adv;
   logic [XLEN-1:0]       w_op1;
   logic [XLEN-1:0]       w_op2;

   logic                  r_valid;
   logic [XLEN-1:0]       r_pc;
   logic [XLEN-1:0]       r_rs1_val;
   logic [XLEN-1:0]       r_rs2_val;
   logic [XLEN-1:0]       r_imm;
   logic [REG_ADDR_W-1:0] r_rd;
   logic [3:0]            r_funct;
   exop_e                 r_op;
   logic                  r_regWrite;
   logic                  r_memRead;
   logic                  r_memWrite;

   assign w_instr    = bus.if_instr;
   assign w_opcode   = w_instr[6:0];
   assign w_rs1      = REG_ADDR_W'(w_instr[19:15]);
   assign w_rs2      = REG_ADDR_W'(w_instr[24:20]);
   assign w_rd_field = REG_ADDR_W'(w_instr[11:7]);

   always_comb begin
      w_op       = EXOP_ILLEGAL;
      w_imm      = '0;
      w_has_rd   = 1'b0;
      w_use1     = 1'b0;
      w_use2     = 1'b0;
      w_memRead  = 1'b0;
      w_memWrite = 1'b0;
      case (w_opcode)
         OPC_OP: begin
            w_op     = EXOP_ALU_R;
            w_has_rd = 1'b1;
            w_use1   = 1'b1;
            w_use2   = 1'b1;
         end
         OPC_OPIMM: begin
            w_op     = EXOP_ALU_I;
            w_imm    = {{20{w_instr[31]}}, w_instr[31:20]};
            w_has_rd = 1'b1;
            w_use1   = 1'b1;
         end
         OPC_LOAD: begin
            w_op      = EXOP_LOAD;
            w_imm     = {{20{w_instr[31]}}, w_instr[31:20]};
            w_has_rd  = 1'b1;
            w_use1    = 1'b1;
            w_memRead = 1'b1;
         end
         OPC_STORE: begin
            w_op       = EXOP_STORE;
            w_imm      = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            w_use1     = 1'b1;
            w_use2     = 1'b1;
            w_memWrite = 1'b1;
         end
         OPC_BRANCH: begin
            w_op   = EXOP_BRANCH;
            w_imm  = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                      w_instr[11:8], 1'b0};
            w_use1 = 1'b1;
            w_use2 = 1'b1;
         end
         OPC_LUI: begin
            w_op     = EXOP_LUI;
            w_imm    = {w_instr[31:12], 12'b0};
            w_has_rd = 1'b1;
         end
         OPC_AUIPC: begin
            w_op     = EXOP_AUIPC;
            w_imm    = {w_instr[31:12], 12'b0};
            w_has_rd = 1'b1;
         end
         OPC_JAL: begin
            w_op     = EXOP_JAL;
            w_imm    = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                        w_instr[30:21], 1'b0};
            w_has_rd = 1'b1;
         end
         OPC_JALR: begin
            w_op     = EXOP_JALR;
            w_imm    = {{20{w_instr[31]}}, w_instr[31:20]};
            w_has_rd = 1'b1;
            w_use1   = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_rd       = w_has_rd ? w_rd_field : '0;
   assign w_regWrite = w_has_rd & (w_rd != '0);

   // Only a load still sitting in ID/EX can stall; its data is not yet available for forwarding.
   assign w_hazard = r_valid & r_memRead & (r_rd != '0) & bus.if_valid &
                     ((w_use1 & (w_rs1 == r_rd)) | (w_use2 & (w_rs2 == r_rd)));
   assign w_adv    = ~r_valid | bus.ex_ready;

`ifdef WB_BYPASS_EN
   assign w_op1 = (bus.wb_regWrite && (bus.wb_writeReg == w_rs1) && (w_rs1 != '0))
                  ? bus.wb_writeData : bus.data1;
   assign w_op2 = (bus.wb_regWrite && (bus.wb_writeReg == w_rs2) && (w_rs2 != '0))
                  ? bus.wb_writeData : bus.data2;
`else
   logic w_unused_wb;
   assign w_unused_wb = ^{bus.wb_regWrite, bus.wb_writeReg, bus.wb_writeData};
   assign w_op1       = bus.data1;
   assign w_op2       = bus.data2;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_pc       <= '0;
         r_rs1_val  <= '0;
         r_rs2_val  <= '0;
         r_imm      <= '0;
         r_rd       <= '0;
         r_funct    <= '0;
         r_op       <= EXOP_ALU_R;
         r_regWrite <= 1'b0;
         r_memRead  <= 1'b0;
         r_memWrite <= 1'b0;
      end else if (bus.flush || (w_adv && w_hazard)) begin
         r_valid    <= 1'b0;
         r_regWrite <= 1'b0;
         r_memRead  <= 1'b0;
         r_memWrite <= 1'b0;
      end else if (w_adv) begin
         r_valid    <= bus.if_valid;
         r_pc       <= bus.if_pc;
         r_rs1_val  <= w_op1;
         r_rs2_val  <= w_op2;
         r_imm      <= XLEN'($signed(w_imm));
         r_rd       <= w_rd;
         r_funct    <= {w_instr[30], w_instr[14:12]};
         r_op       <= w_op;
         r_regWrite <= bus.if_valid & w_regWrite;
         r_memRead  <= bus.if_valid & w_memRead;
         r_memWrite <= bus.if_valid & w_memWrite;
      end
   end

   assign bus.id_ready    = w_adv & ~w_hazard;
   assign bus.read1       = w_rs1;
   assign bus.read2       = w_rs2;
   assign bus.ex_valid    = r_valid;
   assign bus.ex_pc       = r_pc;
   assign bus.ex_rs1_val  = r_rs1_val;
   assign bus.ex_rs2_val  = r_rs2_val;
   assign bus.ex_imm      = r_imm;
   assign bus.ex_rd       = r_rd;
   assign bus.ex_funct    = r_funct;
   assign bus.ex_op       = r_op;
   assign bus.ex_regWrite = r_regWrite;
   assign bus.ex_memRead  = r_memRead;
   assign bus.ex_memWrite = r_memWrite;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// compared against a behavioural ID/EX model.
module tb_decode_stage;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   decode_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

   decode_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks;
   int errors;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [3:0]  funct;
      logic [3:0]  op;
      logic        rw;
      logic        mr;
      logic        mw;
   } ex_t;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        u1;
      logic        u2;
      logic        rw;
      logic        mr;
      logic        mw;
   } dec_t;

   ex_t m;

   function automatic logic [31:0] sext(longint v, int bits);
      longint r = v;
      if (r >= (longint'(1) << (bits - 1))) r = r - (longint'(1) << bits);
      return 32'(r);
   endfunction

   // Reference decode: field values assembled arithmetically from the instruction bits.
   function automatic dec_t ref_decode(logic [31:0] ins);
      dec_t   d;
      longint v;
      logic   wr;
      d  = '0;
      wr = 1'b0;
      case (ins[6:0])
         7'h33: begin d.op = 0; d.u1 = 1; d.u2 = 1; wr = 1; end
         7'h13: begin d.op = 1; d.u1 = 1; wr = 1; d.imm = sext(longint'(ins[31:20]), 12); end
         7'h03: begin d.op = 2; d.u1 = 1; wr = 1; d.mr = 1; d.imm = sext(longint'(ins[31:20]), 12); end
         7'h23: begin
            d.op = 3; d.u1 = 1; d.u2 = 1; d.mw = 1;
            v = 32 * longint'(ins[31:25]) + longint'(ins[11:7]);
            d.imm = sext(v, 12);
         end
         7'h63: begin
            d.op = 4; d.u1 = 1; d.u2 = 1;
            v = 4096 * longint'(ins[31]) + 2048 * longint'(ins[7]) +
                32 * longint'(ins[30:25]) + 2 * longint'(ins[11:8]);
            d.imm = sext(v, 13);
         end
         7'h37: begin d.op = 5; wr = 1; d.imm = 32'(4096 * longint'(ins[31:12])); end
         7'h17: begin d.op = 6; wr = 1; d.imm = 32'(4096 * longint'(ins[31:12])); end
         7'h6F: begin
            d.op = 7; wr = 1;
            v = 1048576 * longint'(ins[31]) + 4096 * longint'(ins[19:12]) +
                2048 * longint'(ins[20]) + 2 * longint'(ins[30:21]);
            d.imm = sext(v, 21);
         end
         7'h67: begin d.op = 8; d.u1 = 1; wr = 1; d.imm = sext(longint'(ins[31:20]), 12); end
         default: d.op = 15;
      endcase
      d.rd = wr ? ins[11:7] : 5'd0;
      d.rw = (d.rd != 0);
      return d;
   endfunction

   function automatic logic [31:0] ref_operand(logic [4:0] rs, logic [31:0] rf);
      logic [31:0] r = rf;
`ifdef WB_BYPASS_EN
      if (bus.wb_regWrite && bus.wb_writeReg == rs && rs != 0) r = bus.wb_writeData;
`endif
      return r;
   endfunction

   function automatic logic model_hazard();
      dec_t d = ref_decode(bus.if_instr);
      logic [4:0] s1 = bus.if_instr[19:15];
      logic [4:0] s2 = bus.if_instr[24:20];
      return m.valid && m.mr && (m.rd != 0) && bus.if_valid &&
             ((d.u1 && s1 == m.rd) || (d.u2 && s2 == m.rd));
   endfunction

   function automatic logic model_ready();
      return (!m.valid || bus.ex_ready) && !model_hazard();
   endfunction

   task automatic model_step();
      dec_t d = ref_decode(bus.if_instr);
      logic adv = !m.valid || bus.ex_ready;
      if (rst) begin
         m = '0;
      end else if (bus.flush || (adv && model_hazard())) begin
         m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0;
      end else if (adv) begin
         m.valid = bus.if_valid;
         m.pc    = bus.if_pc;
         m.rs1   = ref_operand(bus.if_instr[19:15], bus.data1);
         m.rs2   = ref_operand(bus.if_instr[24:20], bus.data2);
         m.imm   = d.imm;
         m.rd    = d.rd;
         m.funct = {bus.if_instr[30], bus.if_instr[14:12]};
         m.op    = d.op;
         m.rw    = d.rw & bus.if_valid;
         m.mr    = d.mr & bus.if_valid;
         m.mw    = d.mw & bus.if_valid;
      end
   endtask

   function automatic ex_t dut_ex();
      return {bus.ex_valid, bus.ex_pc, bus.ex_rs1_val, bus.ex_rs2_val, bus.ex_imm,
              bus.ex_rd, bus.ex_funct, bus.ex_op, bus.ex_regWrite, bus.ex_memRead,
              bus.ex_memWrite};
   endfunction

   task automatic set_in(logic v, logic [31:0] ins, logic [31:0] pc, logic [31:0] d1,
                         logic [31:0] d2, logic exr, logic fl);
      bus.if_valid = v;
      bus.if_instr = ins;
      bus.if_pc    = pc;
      bus.data1    = d1;
      bus.data2    = d2;
      bus.ex_ready = exr;
      bus.flush    = fl;
      #1;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(1, 32'hFFD08293, 32'h40, 32'h9, 32'h9, 1, 0);
      tick();
      tick();
      checks++;
      if (dut_ex() !== '0) begin
         errors++;
         $display("FAIL reset_state got %h expected 0", dut_ex());
      end
      rst = 1'b0;
      set_in(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
      checks++;
      if (bus.id_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_id_ready got %b expected 1", bus.id_ready);
      end
   endtask

   task automatic test_addi();
      set_in(1, 32'hFFD08293, 32'h100, 32'd10, 32'd7, 1, 0);
      checks++;
      if (bus.read1 !== 5'd1 || bus.id_ready !== 1'b1) begin
         errors++;
         $display("FAIL addi_id read1=%0d id_ready=%b expected 1/1", bus.read1, bus.id_ready);
      end
      tick();
      checks++;
      if ({bus.ex_valid, bus.ex_op, bus.ex_imm, bus.ex_rd, bus.ex_rs1_val, bus.ex_regWrite,
           bus.ex_memRead, bus.ex_pc} !== {1'b1, 4'd1, 32'hFFFFFFFD, 5'd5, 32'd10, 1'b1, 1'b0, 32'h100}) begin
         errors++;
         $display("FAIL addi_ex valid=%b op=%0d imm=%h rd=%0d rs1=%0d rw=%b pc=%h expected 1/1/fffffffd/5/10/1/100",
                  bus.ex_valid, bus.ex_op, bus.ex_imm, bus.ex_rd, bus.ex_rs1_val, bus.ex_regWrite, bus.ex_pc);
      end
   endtask

   task automatic test_load_use();
      set_in(1, 32'h00012183, 32'h200, 32'h1000, 32'h0, 1, 0);
      tick();
      checks++;
      if ({bus.ex_valid, bus.ex_op, bus.ex_memRead, bus.ex_rd} !== {1'b1, 4'd2, 1'b1, 5'd3}) begin
         errors++;
         $display("FAIL lw_ex valid=%b op=%0d mr=%b rd=%0d expected 1/2/1/3",
                  bus.ex_valid, bus.ex_op, bus.ex_memRead, bus.ex_rd);
      end
      set_in(1, 32'h00118233, 32'h204, 32'h3, 32'h1, 1, 0);
      checks++;
      if (bus.id_ready !== 1'b0) begin
         errors++;
         $display("FAIL loaduse_stall id_ready=%b expected 0", bus.id_ready);
      end
      tick();
      checks++;
      if ({bus.ex_valid, bus.ex_regWrite, bus.ex_memRead} !== 3'b000) begin
         errors++;
         $display("FAIL loaduse_bubble valid/rw/mr=%b%b%b expected 000",
                  bus.ex_valid, bus.ex_regWrite, bus.ex_memRead);
      end
      checks++;
      if (bus.id_ready !== 1'b1) begin
         errors++;
         $display("FAIL loaduse_release id_ready=%b expected 1", bus.id_ready);
      end
      tick();
      checks++;
      if ({bus.ex_valid, bus.ex_op, bus.ex_rd, bus.ex_pc} !== {1'b1, 4'd0, 5'd4, 32'h204}) begin
         errors++;
         $display("FAIL loaduse_add valid=%b op=%0d rd=%0d pc=%h expected 1/0/4/204",
                  bus.ex_valid, bus.ex_op, bus.ex_rd, bus.ex_pc);
      end
      set_in(1, 32'h00012003, 32'h300, 32'h0, 32'h0, 1, 0);
      tick();
      set_in(1, 32'h00100233, 32'h304, 32'h0, 32'h1, 1, 0);
      checks++;
      if (bus.id_ready !== 1'b1) begin
         errors++;
         $display("FAIL x0_no_stall id_ready=%b expected 1", bus.id_ready);
      end
      tick();
      checks++;
      if ({bus.ex_valid, bus.ex_pc} !== {1'b1, 32'h304}) begin
         errors++;
         $display("FAIL x0_add valid=%b pc=%h expected 1/304", bus.ex_valid, bus.ex_pc);
      end
   endtask

   task automatic test_stall_flush();
      set_in(1, 32'hFFD08293, 32'h400, 32'h1234, 32'h5, 1, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         set_in(1, 32'h00118233, 32'h404 + 32'(i), 32'h99, 32'h98, 0, 0);
         checks++;
         if (bus.id_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_id_ready cycle %0d got %b expected 0", i, bus.id_ready);
         end
         tick();
         checks++;
         if ({bus.ex_valid, bus.ex_pc, bus.ex_rs1_val, bus.ex_imm, bus.ex_rd, bus.ex_op, bus.ex_regWrite}
             !== {1'b1, 32'h400, 32'h1234, 32'hFFFFFFFD, 5'd5, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL stall_hold cycle %0d valid=%b pc=%h rs1=%h imm=%h rd=%0d op=%0d expected 1/400/1234/fffffffd/5/1",
                     i, bus.ex_valid, bus.ex_pc, bus.ex_rs1_val, bus.ex_imm, bus.ex_rd, bus.ex_op);
         end
      end
      set_in(1, 32'h00118233, 32'h404, 32'h99, 32'h98, 0, 1);
      tick();
      checks++;
      if ({bus.ex_valid, bus.ex_regWrite} !== 2'b00) begin
         errors++;
         $display("FAIL flush valid=%b rw=%b expected 0/0", bus.ex_valid, bus.ex_regWrite);
      end
   endtask

   task automatic test_store_illegal();
      set_in(1, 32'h00712423, 32'h500, 32'h1000, 32'h77, 1, 0);
      tick();
      checks++;
      if ({bus.ex_valid, bus.ex_op, bus.ex_imm, bus.ex_memWrite, bus.ex_regWrite, bus.ex_rd, bus.ex_rs2_val}
          !== {1'b1, 4'd3, 32'd8, 1'b1, 1'b0, 5'd0, 32'h77}) begin
         errors++;
         $display("FAIL sw valid=%b op=%0d imm=%h mw=%b rw=%b rd=%0d rs2=%h expected 1/3/8/1/0/0/77",
                  bus.ex_valid, bus.ex_op, bus.ex_imm, bus.ex_memWrite, bus.ex_regWrite, bus.ex_rd, bus.ex_rs2_val);
      end
      set_in(1, 32'h0000007F, 32'h504, 32'h0, 32'h0, 1, 0);
      tick();
      checks++;
      if ({bus.ex_valid, bus.ex_op, bus.ex_regWrite, bus.ex_memRead, bus.ex_memWrite}
          !== {1'b1, 4'd15, 3'b000}) begin
         errors++;
         $display("FAIL illegal valid=%b op=%0d rw/mr/mw=%b%b%b expected 1/15/000",
                  bus.ex_valid, bus.ex_op, bus.ex_regWrite, bus.ex_memRead, bus.ex_memWrite);
      end
   endtask

   task automatic test_bypass();
      logic [31:0] exp_val;
`ifdef WB_BYPASS_EN
      exp_val = 32'h55;
`else
      exp_val = 32'h11;
`endif
      bus.wb_regWrite  = 1'b1;
      bus.wb_writeReg  = 5'd1;
      bus.wb_writeData = 32'h55;
      set_in(1, 32'h00008293, 32'h600, 32'h11, 32'h22, 1, 0);
      tick();
      checks++;
      if (bus.ex_rs1_val !== exp_val) begin
         errors++;
         $display("FAIL wb_bypass rs1=%h expected %h", bus.ex_rs1_val, exp_val);
      end
      bus.wb_writeReg = 5'd0;
      set_in(1, 32'h00000293, 32'h604, 32'h11, 32'h22, 1, 0);
      tick();
      checks++;
      if (bus.ex_rs1_val !== 32'h11) begin
         errors++;
         $display("FAIL wb_bypass_x0 rs1=%h expected 11", bus.ex_rs1_val);
      end
      bus.wb_regWrite = 1'b0;
   endtask

   task automatic test_random();
      logic [6:0]  opcs [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17,
                                 7'h6F, 7'h67, 7'h7F, 7'h0B};
      logic [31:0] ins;
      ex_t         got;
      for (int i = 0; i < 600; i++) begin
         ins        = $urandom();
         ins[6:0]   = opcs[$urandom_range(0, 10)];
         ins[11:7]  = 5'($urandom_range(0, 3));
         ins[19:15] = 5'($urandom_range(0, 3));
         ins[24:20] = 5'($urandom_range(0, 3));
         rst              = ($urandom_range(0, 99) == 0);
         bus.wb_regWrite  = 1'($urandom_range(0, 1));
         bus.wb_writeReg  = 5'($urandom_range(0, 3));
         bus.wb_writeData = $urandom();
         set_in(($urandom_range(0, 9) < 8), ins, $urandom(), $urandom(), $urandom(),
                ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
         checks++;
         if (bus.id_ready !== model_ready()) begin
            errors++;
            $display("FAIL rand_id_ready iter %0d got %b expected %b", i, bus.id_ready, model_ready());
         end
         tick();
         got = dut_ex();
         checks++;
         if (m.valid) begin
            if (got !== m) begin
               errors++;
               $display("FAIL rand_ex iter %0d got %h expected %h", i, got, m);
            end
         end else if ({got.valid, got.rw, got.mr, got.mw} !== 4'b0000) begin
            errors++;
            $display("FAIL rand_ex_invalid iter %0d valid/rw/mr/mw got %b%b%b%b expected 0000",
                     i, got.valid, got.rw, got.mr, got.mw);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      rst              = 1'b1;
      bus.wb_regWrite  = 1'b0;
      bus.wb_writeReg  = '0;
      bus.wb_writeData = '0;
      bus.flush        = 1'b0;
      bus.ex_ready     = 1'b1;
      bus.if_valid     = 1'b0;
      bus.if_instr     = '0;
      bus.if_pc        = '0;
      bus.data1        = '0;
      bus.data2        = '0;
      test_reset();
      test_addi();
      test_load_use();
      test_stall_flush();
      test_store_illegal();
      test_bypass();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
